instruction_encoder: RTL

Encodes symbolic instruction requests (operation select plus register, immediate and jump-target fields) into 32-bit MIPS instruction words. Each encoded word is tagged with a sequential instruction-memory word address and streamed out over a valid/ready handshake. The block sits upstream of instruction memory as the program loader used by the single-cycle CPU testbenches. It is the inverse of the CPU's instruction decoder and covers the same eleven instructions.

---
 rtl/instruction_encoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - MIPS instruction encoder feeding a 2-entry addressed output FIFO
// Optional feature macro: ENCODER_ILLEGAL_TRAP_EN (drop illegal ops and raise sticky illegal_op).
module instruction_encoder #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instruction,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  done,
  output logic                  illegal_op
);

  localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);

  logic [31:0]           r_word [2];
  logic [ADDR_WIDTH-1:0] r_addr [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic [ADDR_WIDTH-1:0] r_addr_ctr;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic                  r_done;

  logic [31:0] w_word;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
`ifdef ENCODER_ILLEGAL_TRAP_EN
  logic        w_legal;
  logic        r_illegal;
`endif

  always_comb begin
    w_word = 32'h0000_0000;
`ifdef ENCODER_ILLEGAL_TRAP_EN
    w_legal = 1'b1;
`endif
    case (in_op)
      4'd0:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h21};
      4'd1:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h20};
      4'd2:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h2A};
      4'd3:  w_word = {6'h00, in_rs, 5'h00, 5'h00, 5'h00, 6'h08};
      4'd4:  w_word = {6'h09, in_rs, in_rt, in_imm};
      4'd5:  w_word = {6'h08, in_rs, in_rt, in_imm};
      4'd6:  w_word = {6'h03, in_target};
      4'd7:  w_word = {6'h05, in_rs, in_rt, in_imm};
      4'd8:  w_word = {6'h04, in_rs, in_rt, in_imm};
      4'd9:  w_word = {6'h2B, in_rs, in_rt, in_imm};
      4'd10: w_word = {6'h23, in_rs, in_rt, in_imm};
      default: begin
        w_word = 32'h0000_0000;
`ifdef ENCODER_ILLEGAL_TRAP_EN
        w_legal = 1'b0;
`endif
      end
    endcase
  end

  assign in_ready  = (r_count != 2'd2) && !r_done;
  assign out_valid = (r_count != 2'd0);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

`ifdef ENCODER_ILLEGAL_TRAP_EN
  assign w_push     = w_accept && w_legal;
  assign illegal_op = r_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else if (w_accept && !w_legal) begin
      r_illegal <= 1'b1;
    end
  end
`else
  assign w_push     = w_accept;
  assign illegal_op = 1'b0;
`endif

  // Push cannot coincide with a full FIFO, and pop never happens when empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word       <= '{default: '0};
      r_addr       <= '{default: '0};
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= 2'd0;
      r_addr_ctr   <= LP_BASE;
      r_word_count <= '0;
      r_done       <= 1'b0;
    end else begin
      if (w_push) begin
        r_word[r_wr_ptr] <= w_word;
        r_addr[r_wr_ptr] <= r_addr_ctr;
        r_wr_ptr         <= ~r_wr_ptr;
        r_addr_ctr       <= r_addr_ctr + ADDR_WIDTH'(1);
        r_word_count     <= r_word_count + (ADDR_WIDTH+1)'(1);
        if (&r_addr_ctr) begin
          r_done <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_instruction = r_word[r_rd_ptr];
  assign out_addr        = r_addr[r_rd_ptr];
  assign word_count      = r_word_count;
  assign done            = r_done;

endmodule
